// File: rtl/popcount_frame_accum.sv
// rtl/popcount_frame_accum.sv - per-frame set-bit accumulator with valid/ready result port
// Optional POPCOUNT_FRAME_ACCUM_PASSTHRU_EN lets a new word enter while the result is consumed.
module popcount_frame_accum #(
  parameter int width_p     = 8,
  parameter int max_words_p = 16
) (
  input  logic                                      clk_i,
  input  logic                                      reset_n_i,
  input  logic                                      valid_i,
  output logic                                      ready_o,
  input  logic [width_p-1:0]                        data_i,
  input  logic                                      last_i,
  output logic                                      valid_o,
  input  logic                                      ready_i,
  output logic [$clog2(width_p*max_words_p+1)-1:0]  count_o,
  output logic [$clog2(max_words_p+1)-1:0]          words_o,
  output logic                                      overflow_o
);

  localparam int CW = $clog2(width_p*max_words_p+1);
  localparam int WW = $clog2(max_words_p+1);
  localparam int PW = $clog2(width_p+1);
  localparam logic [WW-1:0] MAX_W = WW'(max_words_p);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   total, total_n;
  logic [WW-1:0]   words, words_n;
  logic            ovf, ovf_n;
  logic [PW-1:0]   pc;
  logic [WW-1:0]   words_inc;
  logic            at_max;

  always_comb begin
    pc = '0;
    for (int i = 0; i < width_p; i++) begin
      pc = pc + PW'(data_i[i]);
    end
  end

  assign words_inc = words + WW'(1);
  assign at_max    = (words_inc == MAX_W);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= ACCUM;
      total <= '0;
      words <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      total <= total_n;
      words <= words_n;
      ovf   <= ovf_n;
    end
  end

  always_comb begin
    state_n = state;
    total_n = total;
    words_n = words;
    ovf_n   = ovf;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state)
      ACCUM: begin
        ready_o = 1'b1;
        if (valid_i) begin
          total_n = total + CW'(pc);
          words_n = words_inc;
          // force-close without last_i marks the frame as truncated
          ovf_n   = at_max && !last_i;
          if (last_i || at_max) state_n = DONE;
        end
      end
      DONE: begin
        valid_o = 1'b1;
`ifdef POPCOUNT_FRAME_ACCUM_PASSTHRU_EN
        ready_o = ready_i;
`endif
        if (ready_i) begin
          state_n = ACCUM;
          total_n = '0;
          words_n = '0;
          ovf_n   = 1'b0;
`ifdef POPCOUNT_FRAME_ACCUM_PASSTHRU_EN
          // word accepted alongside the consume opens the next frame on its own
          if (valid_i) begin
            total_n = CW'(pc);
            words_n = WW'(1);
            ovf_n   = (MAX_W == WW'(1)) && !last_i;
            if (last_i || (MAX_W == WW'(1))) state_n = DONE;
          end
`endif
        end
      end
      default: state_n = ACCUM;
    endcase
  end

  assign count_o    = total;
  assign words_o    = words;
  assign overflow_o = ovf;

endmodule

// File: tb/tb_popcount_frame_accum.sv
// tb/tb_popcount_frame_accum.sv - directed self-checking bench for popcount_frame_accum
module tb_popcount_frame_accum;

  localparam int W  = 8;
  localparam int M  = 16;
  localparam int CW = $clog2(W*M+1);
  localparam int WW = $clog2(M+1);
`ifdef POPCOUNT_FRAME_ACCUM_PASSTHRU_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 2;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [W-1:0]  data_i = '0;
  logic          last_i = 1'b0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [CW-1:0] count_o;
  logic [WW-1:0] words_o;
  logic          overflow_o;

  int n_checks = 0;
  int n_fail   = 0;

  popcount_frame_accum #(.width_p(W), .max_words_p(M)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .last_i(last_i), .valid_o(valid_o), .ready_i(ready_i),
    .count_o(count_o), .words_o(words_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_result(input string tag, input int cnt, input int wds, input int ovf);
    chk({tag, "_valid"}, 32'(valid_o), 1);
    chk({tag, "_count"}, 32'(count_o), cnt);
    chk({tag, "_words"}, 32'(words_o), wds);
    chk({tag, "_ovf"}, 32'(overflow_o), ovf);
  endtask

  task automatic send(input logic [W-1:0] d, input logic l);
    int guard;
    guard = 0;
    valid_i = 1'b1;
    data_i  = d;
    last_i  = l;
    while (!ready_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("send_ready", 32'(ready_o), 1);
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    last_i  = 1'b0;
    data_i  = W'($urandom);
  endtask

  task automatic consume(input string tag);
    ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready_i = 1'b0;
    chk({tag, "_post_valid"}, 32'(valid_o), 0);
    chk({tag, "_post_ready"}, 32'(ready_o), 1);
  endtask

  logic [W-1:0] pt_data [4] = '{8'h01, 8'h03, 8'h07, 8'h0F};

  initial begin
    int idx, nres, last_cyc;
    logic acc;

    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_ready", 32'(ready_o), 1);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_words", 32'(words_o), 0);
    chk("rst_ovf", 32'(overflow_o), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // single frame
    send(8'hFF, 1'b0);
    send(8'h0F, 1'b0);
    chk("f1_not_yet", 32'(valid_o), 0);
    send(8'h01, 1'b1);
    chk_result("f1", 13, 3, 0);
    chk("f1_ready_low", 32'(ready_o), 0);
    consume("f1");

    // backpressure
    send(8'hAA, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk_result("bp", 4, 1, 0);
      chk("bp_ready", 32'(ready_o), 0);
      @(negedge clk);
    end
    consume("bp");

    // force-close at max_words_p
    for (int i = 0; i < M; i++) send(8'hFF, 1'b0);
    chk_result("fc1", 128, 16, 1);
    consume("fc1");
    send(8'hFF, 1'b1);
    chk_result("fc2", 8, 1, 0);
    consume("fc2");

    // input stalls with junk data while invalid
    send(8'h03, 1'b0);
    for (int i = 0; i < 3; i++) begin
      data_i = ~data_i;
      last_i = 1'b1;
      @(negedge clk);
    end
    last_i = 1'b0;
    chk("st_hold_valid", 32'(valid_o), 0);
    chk("st_hold_count", 32'(count_o), 2);
    send(8'h30, 1'b1);
    chk_result("st", 4, 2, 0);
    consume("st");

    // async reset mid-frame
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    chk("mr_partial", 32'(count_o), 4);
    #1 reset_n = 1'b0;
    #1;
    chk("mr_count", 32'(count_o), 0);
    chk("mr_words", 32'(words_o), 0);
    chk("mr_valid", 32'(valid_o), 0);
    chk("mr_ready", 32'(ready_o), 1);
    #1 reset_n = 1'b1;
    @(negedge clk);
    send(8'h80, 1'b1);
    chk_result("mr", 1, 1, 0);
    consume("mr");

    // reset while DONE drops the result
    send(8'h0F, 1'b1);
    chk("rd_valid_pre", 32'(valid_o), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("rd_valid", 32'(valid_o), 0);
    chk("rd_count", 32'(count_o), 0);
    #1 reset_n = 1'b1;
    @(negedge clk);

    // back-to-back one-word frames
    ready_i  = 1'b1;
    idx      = 0;
    nres     = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 30 && nres < 4; cyc++) begin
      if (valid_o) begin
        chk($sformatf("pt_count%0d", nres), 32'(count_o), nres + 1);
        if (nres > 0) chk("pt_gap", 32'(cyc - last_cyc), GAP);
        last_cyc = cyc;
        nres++;
      end
      if (idx < 4) begin
        valid_i = 1'b1;
        data_i  = pt_data[idx];
        last_i  = 1'b1;
      end else begin
        valid_i = 1'b0;
        last_i  = 1'b0;
      end
      acc = valid_i && ready_o;
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
    chk("pt_results", 32'(nres), 4);
    @(negedge clk);
    ready_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/popcount_frame_accum.md
Name: popcount_frame_accum

Overview:
- Sequential stage directly upstream of the combinational countones consumer path.
- Accepts a stream of width_p-bit words over a valid/ready handshake, each frame delimited by last_i.
- Per accepted word it adds the number of set bits to a running total. At frame end it presents the total and the word count on a valid/ready output port.
- Downstream logic receives frame-level ones counts instead of per-word counts.

Parameters:
- width_p, 8, data word width in bits (>=1).
- max_words_p, 16, maximum words per frame; the frame is force-closed at this length.

Ports:
- clk_i  input  1  clock, rising edge.
- reset_n_i  input  1  asynchronous active-low reset.
- valid_i  input  1  upstream word valid.
- ready_o  output  1  block can accept a word this cycle.
- data_i  input  width_p  word to count.
- last_i  input  1  word is the final word of its frame.
- valid_o  output  1  frame result valid.
- ready_i  input  1  downstream accepts the result.
- count_o  output  $clog2(width_p*max_words_p+1)  total set bits in the frame.
- words_o  output  $clog2(max_words_p+1)  number of words in the frame (1..max_words_p).
- overflow_o  output  1  frame was force-closed at max_words_p without last_i.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (reset_n_i). Reset is effective immediately on assertion and released synchronously.
- Reset values: state=ACCUM, count_o=0, words_o=0, overflow_o=0, valid_o=0, ready_o=1.
- Input handshake: a word is accepted when valid_i && ready_o on a rising edge.
- Output handshake: a result is consumed when valid_o && ready_i on a rising edge.
- State ACCUM:
  - ready_o=1, valid_o=0.
  - On accept: total += popcount(data_i) (zero-extended, no saturation needed), words += 1.
  - If last_i=1, or words reaches max_words_p on this accept, go to DONE next cycle.
  - overflow is set if words reached max_words_p and last_i=0.
  - First word of a frame: total and words restart from that word alone; no stale carry-in from the previous frame.
- State DONE:
  - valid_o=1, ready_o=0 (base build).
  - count_o, words_o and overflow_o are held stable until consumed.
  - On consume: return to ACCUM with total=0, words=0, overflow=0.
- Latency: valid_o rises the cycle after the closing word is accepted. Minimum frame period is 2 cycles (1-word frame, ready_i held high).
- Stall: valid_i may drop mid-frame; the accumulation holds its value.
- Outputs: count_o and words_o always reflect the registered running values. During ACCUM they show partial totals and are meaningful only when valid_o=1.
- Overflow frame: words arriving after a force-close belong to a new frame. The upstream last_i is still honoured on a later word.
- Data on invalid cycles: data_i and last_i are ignored when valid_i=0.
- Mid-frame reset: the partial frame is discarded and no result is emitted.
- Reset while DONE: the result is dropped and valid_o=0 immediately.

Optional Feature:
- Macro: POPCOUNT_FRAME_ACCUM_PASSTHRU_EN.
- Defined:
  - In DONE, ready_o = ready_i (combinational).
  - A word accepted in the same cycle the result is consumed starts the next frame: total=popcount(word), words=1, state=ACCUM.
  - If that word also has last_i=1 (or max_words_p==1), the state stays DONE with the new result.
  - This gives back-to-back 1-word frames at 1 frame per cycle.
- Undefined: ready_o=0 throughout DONE, giving one bubble cycle per frame.

Test Plan:
- Reset then single frame:
  - Stimulus: words 8'hFF, 8'h0F, 8'h01 (last on third).
  - Required: valid_o one cycle after the third accept, with count_o=13, words_o=3, overflow_o=0.
- Backpressure:
  - Stimulus: frame 8'hAA (last); hold ready_i=0 for 5 cycles.
  - Required: valid_o=1, count_o=4, words_o=1 stable throughout; ready_o=0; consumed on ready_i=1; next cycle valid_o=0, ready_o=1.
- Force-close:
  - Stimulus: 17 words of 8'hFF with last_i only on word 17.
  - Required: first result count_o=128, words_o=16, overflow_o=1; second result count_o=8, words_o=1, overflow_o=0.
- Input stalls:
  - Stimulus: words 8'h03 and 8'h30 (last), with valid_i low for 3 cycles between them.
  - Required: count_o=4, words_o=2; data_i toggled while valid_i=0 does not affect the result.
- Async reset mid-frame:
  - Stimulus: 2 words accepted, then reset_n_i pulsed low between clock edges.
  - Required: outputs are at reset values before the next edge; a following frame 8'h80 (last) gives count_o=1, words_o=1.
- PASSTHRU_EN:
  - Stimulus: ready_i=1 and four consecutive 1-word frames 8'h01, 8'h03, 8'h07, 8'h0F.
  - Required: results 1, 2, 3, 4 on consecutive cycles.
  - Without the macro: one idle cycle between each result.
